// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit holding the HI/LO registers
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     prod_s, prod_u;
  logic            sgn;
  logic [31:0]     da, db, uq, ur, quo, rem;
  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
  // Results from the latched operands; signed divide goes through magnitudes so
  // truncation toward zero and the 0x80000000 / -1 case fall out naturally.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    sgn    = (op_q == OP_DIV);
    da     = (sgn && a_q[31]) ? -a_q : a_q;
    db     = (sgn && b_q[31]) ? -b_q : b_q;
    uq     = (db == 32'd0) ? 32'd0 : da / db;
    ur     = (db == 32'd0) ? 32'd0 : da % db;
    quo    = (sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem    = (sgn && a_q[31]) ? -ur : ur;
  end
  // Next-state: accept requests only in IDLE, count down in RUN, write HI/LO on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (MDUEN) begin
        case (MDUCtrl)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            state_d = RUN;
            op_d    = MDUCtrl;
            a_d     = A;
            b_d     = B;
            cnt_d   = (MDUCtrl == OP_MULT || MDUCtrl == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV, OP_DIVU: begin
            hi_d = (b_q != 32'd0) ? rem : hi_q;
            lo_d = (b_q != 32'd0) ? quo : lo_q;
          end
          default: ;
        endcase
      end
    end
  end
  // State and architectural registers; reset aborts any running operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven vectors plus hand sequences for mult_div_unit
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;
  int errors = 0;
  int checks = 0;
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .MDUEN(MDUEN), .MDUCtrl(MDUCtrl),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;
  vec_t tv[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic wait_done(input logic [31:0] ph, input logic [31:0] pl, output int n);
    n = 0;
    while (Busy && n < 100) begin
      chk("hold_hi", HI, ph);
      chk("hold_lo", LO, pl);
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    logic [31:0] ph, pl;
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = op; A = a; B = b;
    ph = HI; pl = LO;
    @(posedge clk); #1;
    MDUEN = 1'b0; MDUCtrl = 3'd0;
    wait_done(ph, pl, n);
  endtask
  initial begin
    int n;
    tv[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tv[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    tv[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tv[3]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    tv[4]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h7FFFFFFC, 0};
    tv[5]  = '{3'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    tv[6]  = '{3'd3, 32'h00000005, 32'h0,        32'h12345678, 32'h9ABCDEF0, 10};
    tv[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    tv[8]  = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
    tv[9]  = '{3'd4, 32'h00000001, 32'h0,        32'hC0000000, 32'h80000000, 10};
    tv[10] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    tv[11] = '{3'd7, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'hFFFFFFFD, 0};
    tv[12] = '{3'd0, 32'hCAFEF00D, 32'h2,        32'h00000001, 32'hFFFFFFFD, 0};
    reset_n = 1'b0; MDUEN = 1'b0; MDUCtrl = 3'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, n);
      chk($sformatf("v%0d_cycles", i), 32'(n), 32'(tv[i].cyc));
      chk($sformatf("v%0d_hi", i), HI, tv[i].hi);
      chk($sformatf("v%0d_lo", i), LO, tv[i].lo);
    end
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = 3'd1; A = 32'd3; B = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ign_busy%0d", i), 32'(Busy), 32'd1);
      MDUEN = 1'b1; MDUCtrl = 3'd6;
      A = (i == 0) ? 32'h0000DEAD : $urandom;
      B = $urandom;
    end
    @(posedge clk);
    @(negedge clk);
    chk("ign_busy_fall", 32'(Busy), 32'd0);
    chk("ign_lo", LO, 32'd12);
    chk("ign_hi", HI, 32'd0);
    MDUEN = 1'b1; MDUCtrl = 3'd4; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    MDUEN = 1'b0; MDUCtrl = 3'd0;
    chk("b2b_start", 32'(Busy), 32'd1);
    wait_done(32'd0, 32'd12, n);
    chk("b2b_cycles", 32'(n), 32'd10);
    chk("b2b_lo", LO, 32'd14);
    chk("b2b_hi", HI, 32'd2);
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = 3'd3; A = 32'hFFFFFF9C; B = 32'd3;
    @(posedge clk); #1;
    MDUEN = 1'b0; MDUCtrl = 3'd0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    @(posedge clk); #1;
    chk("abort_hold_busy", 32'(Busy), 32'd0);
    chk("abort_hold_lo", LO, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    do_op(3'd1, 32'd6, 32'd7, n);
    chk("post_rst_cycles", 32'(n), 32'd5);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd42);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit; consumes MDUEN/MDUCtrl from the main decoder plus the forwarded rs/rt operands.
- Runs multi-cycle mult/multu/div/divu and single-cycle mthi/mtlo.
- Holds the architectural HI/LO registers read by mfhi/mflo.
- Exposes Busy so the hazard unit can stall subsequent MDU instructions.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, Busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MDUEN  input  1  operation request, valid for one cycle while the instruction is in E.
- MDUCtrl  input  3  op select: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- A  input  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  input  32  rt operand (divisor / multiplier).
- Busy  output  1  multi-cycle operation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (async assert, sync release): Busy=0, HI=0, LO=0, state IDLE, counter=0, operand latches cleared.
- States: IDLE, RUN. The counter width is sized from max(MULT_CYCLES, DIV_CYCLES).
- IDLE, MDUEN=1, MDUCtrl in {001..100}:
  - At the posedge, latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy=1 from the next cycle.
- RUN: counter decrements each posedge. On the posedge where counter reaches 1 (Busy has been high exactly N cycles):
  - Write HI/LO from the latched operands.
  - Go to IDLE; Busy=0.
  - New HI/LO are visible in the same cycle Busy falls.
- Results are computed from the latched operands, never from live A/B; A/B may change freely during RUN.
- mult: signed 64-bit product, {HI,LO}=A*B.
- multu: unsigned 64-bit product, {HI,LO}=A*B.
- div (signed):
  - LO=quotient, truncated toward zero.
  - HI=remainder, with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu (unsigned): LO=A/B, HI=A%B.
- Divide by zero (B=0, div or divu): the operation still runs DIV_CYCLES with Busy=1, but HI/LO are left unchanged.
- mthi/mtlo in IDLE: HI (or LO)=A at the posedge; Busy stays 0; the other register is unchanged.
- MDUEN=1 with MDUCtrl 000/111: no-op. MDUEN=0: MDUCtrl ignored.
- MDUEN=1 while Busy=1 (any op, including mthi/mtlo): ignored, with no effect on the running operation.
  - The hazard unit must stall MDU instructions while Busy|start; the unit does not queue requests.
- Back-to-back: a request in the cycle Busy falls is accepted, since the state is IDLE at that posedge. This gives zero dead cycles between operations.
- reset_n asserted mid-RUN: aborts immediately; Busy=0, HI/LO=0; no partial write.
- HI/LO outputs are registers; there is no combinational path from A/B to HI/LO.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged while Busy.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=-7 (0xFFFFFFF9), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated the cycle after each, Busy never asserts. Then div with B=0 -> Busy 10 cycles, HI/LO remain 0x12345678/0x9ABCDEF0.
- Start mult (A=3, B=4); during Busy present mtlo A=0xDEAD and change A/B every cycle -> request ignored; final LO=12, HI=0. Issue divu (A=100, B=7) in the cycle Busy falls -> accepted, LO=14, HI=2 after 10 cycles.
- Start div; pull reset_n low at Busy cycle 4, asynchronously between clock edges -> Busy, HI and LO go to 0 immediately. Release -> unit idle, a new mult completes normally.
